data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/data_mem_unit.sv | 157 +++++++++++++++
 tb/tb_data_mem_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory unit: access size codes, FSM states
// and byte-lane geometry.
package dmem_pkg;

  typedef enum logic [2:0] {
    CTRL_B  = 3'b000,
    CTRL_H  = 3'b001,
    CTRL_W  = 3'b010,
    CTRL_BU = 3'b100,
    CTRL_HU = 3'b101
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: builds byte enables and replicated store data, and
// extracts/extends load data from a full memory word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        ctrl_i,
  input  logic [1:0]        lane_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] rword_i,
  output logic [LANES-1:0]  be_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  assign byte_sel = rword_i[{lane_i, 3'b000} +: BYTE_W];
  assign half_sel = rword_i[{lane_i[1], 4'b0000} +: HALF_W];

  // Size decode: alignment check, lane enables, store replication, load extension.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    err_o   = 1'b0;
    case (ctrl_i)
      CTRL_B, CTRL_BU: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {LANES{wdata_i[BYTE_W-1:0]}};
        rdata_o = (ctrl_i == CTRL_B) ? {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel}
                                     : {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      end
      CTRL_H, CTRL_HU: begin
        err_o   = lane_i[0];
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[HALF_W-1:0]}};
        rdata_o = (ctrl_i == CTRL_H) ? {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel}
                                     : {{(WORD_W-HALF_W){1'b0}}, half_sel};
      end
      CTRL_W: begin
        err_o   = |lane_i;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Single-port data memory with request/response handshake, programmable
// wait states, sub-word loads/stores and alignment/range checking.
//   state   | meaning
//   IDLE    | ready for a request; captures it on acceptance
//   WAIT    | counting down extra wait states
//   RESP    | one-cycle response strobe; store already committed
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  ctrl_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        cur_we;
  logic [2:0]  cur_ctrl;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] word_idx;
  logic        range_err, lane_err, acc_err;
  logic [LANES-1:0]  be;
  logic [WORD_W-1:0] st_data, ld_data;
  logic [WORD_W-1:0] rd_word_q;
  logic        commit;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  assign accept = req_valid & req_ready;

  // In IDLE the live request drives the datapath so a zero-wait store can
  // commit on its acceptance edge; afterwards the captured copy is used.
  assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign cur_ctrl  = (state_q == ST_IDLE) ? req_ctrl  : ctrl_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  assign word_idx  = cur_addr[AW+1:2];
  assign range_err = |cur_addr[31:AW+2];
  assign acc_err   = range_err | lane_err;

  dmem_lane_align u_align (
    .ctrl_i  (cur_ctrl),
    .lane_i  (cur_addr[1:0]),
    .wdata_i (cur_wdata),
    .rword_i (rd_word_q),
    .be_o    (be),
    .wdata_o (st_data),
    .rdata_o (ld_data),
    .err_o   (lane_err)
  );

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      ctrl_q  <= req_ctrl;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Next-state logic; the counter is loaded with WAIT_CYCLES-1 and exits at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; response fields are live in RESP and held from a register otherwise.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    if (state_q == ST_RESP) begin
      rsp_rdata = (we_q || acc_err) ? '0 : ld_data;
      rsp_err   = acc_err;
    end
  end

  // Hold register for the last response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (rsp_valid) begin
      rdata_q <= rsp_rdata;
      err_q   <= rsp_err;
    end
  end

  // Stores commit on the edge that enters RESP, never under reset.
  assign commit = rst_n && (state_d == ST_RESP) && (state_q != ST_RESP) && cur_we && !acc_err;

  // Byte-enabled RAM with registered read; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (commit && be[i]) mem[word_idx][i*BYTE_W +: BYTE_W] <= st_data[i*BYTE_W +: BYTE_W];
    end
    rd_word_q <= mem[word_idx];
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table plus reset-abort and
// back-to-back sequences.
module tb_data_mem_unit;

  localparam int DEPTH = 256;
  localparam int WAITC = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'b0;
    req_addr = '0; req_wdata = '0;

    vecs.push_back(mk(1, W,    32'h00,  32'h0BADC0DE, 32'h0,        0));
    vecs.push_back(mk(1, W,    32'h10,  32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, W,    32'h10,  32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, W,    32'h20,  32'h11223344, 32'h0,        0));
    vecs.push_back(mk(1, B,    32'h21,  32'hFFFFFFAA, 32'h0,        0));
    vecs.push_back(mk(0, W,    32'h20,  32'h0,        32'h1122AA44, 0));
    vecs.push_back(mk(1, W,    32'h30,  32'h8000FF80, 32'h0,        0));
    vecs.push_back(mk(0, B,    32'h30,  32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, BU,   32'h30,  32'h0,        32'h00000080, 0));
    vecs.push_back(mk(0, H,    32'h32,  32'h0,        32'hFFFF8000, 0));
    vecs.push_back(mk(0, HU,   32'h32,  32'h0,        32'h00008000, 0));
    vecs.push_back(mk(1, W,    32'h40,  32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mk(1, H,    32'h41,  32'h00001234, 32'h0,        1));
    vecs.push_back(mk(0, W,    32'h40,  32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(0, W,    32'h42,  32'h0,        32'h0,        1));
    vecs.push_back(mk(1, W,    32'h400, 32'h55555555, 32'h0,        1));
    vecs.push_back(mk(0, W,    32'h400, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, W,    32'h00,  32'h0,        32'h0BADC0DE, 0));
    vecs.push_back(mk(1, 3'b011, 32'h40, 32'hFFFFFFFF, 32'h0,       1));
    vecs.push_back(mk(0, 3'b110, 32'h40, 32'h0,        32'h0,       1));
    vecs.push_back(mk(0, 3'b111, 32'h10, 32'h0,        32'h0,       1));
    vecs.push_back(mk(0, W,    32'h40,  32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mk(1, H,    32'h42,  32'h0000BEEF, 32'h0,        0));
    vecs.push_back(mk(1, HU,   32'h40,  32'hABCD7777, 32'h0,        0));
    vecs.push_back(mk(0, W,    32'h40,  32'h0,        32'hBEEF7777, 0));
    vecs.push_back(mk(0, B,    32'h43,  32'h0,        32'hFFFFFFBE, 0));
    vecs.push_back(mk(0, BU,   32'h42,  32'h0,        32'h000000EF, 0));
    vecs.push_back(mk(0, H,    32'h40,  32'h0,        32'h00007777, 0));
    vecs.push_back(mk(0, W,    32'hFFFFFFF0, 32'h0,   32'h0,        1));
    vecs.push_back(mk(1, W,    32'h50,  32'hA5A5A5A5, 32'h0,        0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err",   {31'b0, rsp_err}, 32'd0);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, WAITC + 1);
    end

    // Strobe lasts exactly one cycle.
    @(negedge clk);
    chk("rsp_single_cycle", {31'b0, rsp_valid}, 32'd0);

    // Reset during WAIT aborts an uncommitted store.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_ctrl = W;
      req_addr = 32'h50; req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      for (int c = 0; c < 8; c++) begin
        if (rsp_valid) seen++;
        @(negedge clk);
      end
      chk("abort_no_rsp", seen, 0);
      do_req(0, W, 32'h50, 32'h0, rd, er, lat);
      chk("abort_old_data", rd, 32'hA5A5A5A5);
    end

    // Back-to-back with req_valid held high.
    begin
      logic [31:0] bb_addr [4];
      logic [31:0] bb_exp  [4];
      int n_acc, n_rsp, last_acc;
      bb_addr[0] = 32'h10; bb_exp[0] = 32'hDEADBEEF;
      bb_addr[1] = 32'h20; bb_exp[1] = 32'h1122AA44;
      bb_addr[2] = 32'h30; bb_exp[2] = 32'h8000FF80;
      bb_addr[3] = 32'h00; bb_exp[3] = 32'h0BADC0DE;
      n_acc = 0; n_rsp = 0; last_acc = 0;
      req_we = 1'b0; req_ctrl = W;
      for (int cyc = 0; cyc < 60 && n_rsp < 4; cyc++) begin
        @(negedge clk);
        if (rsp_valid) begin
          chk($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata, bb_exp[n_rsp]);
          n_rsp++;
        end
        if (n_acc < 4) begin
          req_addr  = bb_addr[n_acc];
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
        if (req_ready && n_acc < 4) begin
          if (n_acc > 0) chk($sformatf("b2b_interval%0d", n_acc), cyc - last_acc, WAITC + 2);
          last_acc = cyc;
          n_acc++;
        end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", n_acc, 4);
      chk("b2b_responses", n_rsp, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
